// File: rtl/sha2_sigma_unit.sv
// sha2_sigma_unit: pipelined SHA-2 sigma/sum CFU (WIDTH 32 or 64, STAGES 1..4)
// with a valid/ready handshake and an ID tag carried alongside each result.
// Optional build macro SHA2_SIGMA_PERF_CNT_EN adds a perf_ops counter of
// consumed responses.
module sha2_sigma_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_func,
    input  logic [ID_W-1:0]   req_id,
    input  logic [WIDTH-1:0]  req_data0,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ID_W-1:0]   resp_id,
    output logic [WIDTH-1:0]  resp_data
`ifdef SHA2_SIGMA_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ops
`endif
);

    localparam bit IS64 = (WIDTH == 64);

    // Rotate / shift amounts for the selected SHA-2 variant
    localparam int unsigned S0_R1 = IS64 ? 1  : 7;
    localparam int unsigned S0_R2 = IS64 ? 8  : 18;
    localparam int unsigned S0_SH = IS64 ? 7  : 3;
    localparam int unsigned S1_R1 = IS64 ? 19 : 17;
    localparam int unsigned S1_R2 = IS64 ? 61 : 19;
    localparam int unsigned S1_SH = IS64 ? 6  : 10;
    localparam int unsigned U0_R1 = IS64 ? 28 : 2;
    localparam int unsigned U0_R2 = IS64 ? 34 : 13;
    localparam int unsigned U0_R3 = IS64 ? 39 : 22;
    localparam int unsigned U1_R1 = IS64 ? 14 : 6;
    localparam int unsigned U1_R2 = IS64 ? 18 : 11;
    localparam int unsigned U1_R3 = IS64 ? 41 : 25;

    // Reject unsupported configurations at elaboration
    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("sha2_sigma_unit: WIDTH must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("sha2_sigma_unit: STAGES must be in 1..4");
    end

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    logic [WIDTH-1:0] result_c;
    logic             stall_c;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [ID_W-1:0]   id_q   [STAGES];
    logic [ID_W-1:0]   id_d   [STAGES];
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    // Sigma function evaluated ahead of the first stage
    always_comb begin
        result_c = '0;
        case (req_func)
            2'd0:    result_c = ror(req_data0, S0_R1) ^ ror(req_data0, S0_R2) ^ (req_data0 >> S0_SH);
            2'd1:    result_c = ror(req_data0, S1_R1) ^ ror(req_data0, S1_R2) ^ (req_data0 >> S1_SH);
            2'd2:    result_c = ror(req_data0, U0_R1) ^ ror(req_data0, U0_R2) ^ ror(req_data0, U0_R3);
            default: result_c = ror(req_data0, U1_R1) ^ ror(req_data0, U1_R2) ^ ror(req_data0, U1_R3);
        endcase
    end

    // An unconsumed result freezes the whole pipe, bubbles included
    assign stall_c    = vld_q[STAGES-1] && !resp_ready;
    assign req_ready  = !stall_c;
    assign resp_valid = vld_q[STAGES-1];
    assign resp_id    = id_q[STAGES-1];
    assign resp_data  = data_q[STAGES-1];

    // Next-state of the pipe: hold on stall, otherwise shift by one; bubbles carry zeros
    always_comb begin
        vld_d = vld_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            id_d[i]   = id_q[i];
            data_d[i] = data_q[i];
        end
        if (!stall_c) begin
            vld_d[0]  = req_valid;
            id_d[0]   = req_valid ? req_id   : '0;
            data_d[0] = req_valid ? result_c : '0;
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_d[i]  = vld_q[i-1];
                id_d[i]   = id_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Stage registers; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                id_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < STAGES; i++) begin
                id_q[i]   <= id_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef SHA2_SIGMA_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;

    // Count consumed responses, wrapping at 2^32
    always_comb begin
        perf_ops_d = perf_ops_q;
        if (resp_valid && resp_ready) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q <= '0;
        end else begin
            perf_ops_q <= perf_ops_d;
        end
    end

    assign perf_ops = perf_ops_q;
`endif

endmodule

// File: tb/tb_sha2_sigma_unit.sv
// Directed bench for sha2_sigma_unit: three instances (32b/S1, 32b/S3, 64b/S2).
module tb_sha2_sigma_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Instance A: WIDTH=32, STAGES=1
    logic        a_req_valid = 1'b0, a_req_ready, a_resp_valid, a_resp_ready = 1'b1;
    logic [1:0]  a_func = '0;
    logic [3:0]  a_req_id = '0, a_resp_id;
    logic [31:0] a_x = '0, a_resp_data;
`ifdef SHA2_SIGMA_PERF_CNT_EN
    logic [31:0] a_perf;
`endif

    // Instance B: WIDTH=32, STAGES=3
    logic        b_req_valid = 1'b0, b_req_ready, b_resp_valid, b_resp_ready = 1'b1;
    logic [1:0]  b_func = '0;
    logic [3:0]  b_req_id = '0, b_resp_id;
    logic [31:0] b_x = '0, b_resp_data;
`ifdef SHA2_SIGMA_PERF_CNT_EN
    logic [31:0] b_perf;
`endif

    // Instance C: WIDTH=64, STAGES=2
    logic        c_req_valid = 1'b0, c_req_ready, c_resp_valid, c_resp_ready = 1'b1;
    logic [1:0]  c_func = '0;
    logic [3:0]  c_req_id = '0, c_resp_id;
    logic [63:0] c_x = '0, c_resp_data;
`ifdef SHA2_SIGMA_PERF_CNT_EN
    logic [31:0] c_perf;
`endif

    sha2_sigma_unit #(.WIDTH(32), .STAGES(1), .ID_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_func(a_func),
        .req_id(a_req_id), .req_data0(a_x),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_id(a_resp_id), .resp_data(a_resp_data)
`ifdef SHA2_SIGMA_PERF_CNT_EN
        , .perf_ops(a_perf)
`endif
    );

    sha2_sigma_unit #(.WIDTH(32), .STAGES(3), .ID_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_func(b_func),
        .req_id(b_req_id), .req_data0(b_x),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_id(b_resp_id), .resp_data(b_resp_data)
`ifdef SHA2_SIGMA_PERF_CNT_EN
        , .perf_ops(b_perf)
`endif
    );

    sha2_sigma_unit #(.WIDTH(64), .STAGES(2), .ID_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_func(c_func),
        .req_id(c_req_id), .req_data0(c_x),
        .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
        .resp_id(c_resp_id), .resp_data(c_resp_data)
`ifdef SHA2_SIGMA_PERF_CNT_EN
        , .perf_ops(c_perf)
`endif
    );

    // Hand-computed SHA-256 results for x=1, indexed by func
    logic [31:0] tbl_one [4];
    initial begin
        tbl_one[0] = 32'h0200_4000;
        tbl_one[1] = 32'h0000_A000;
        tbl_one[2] = 32'h4008_0400;
        tbl_one[3] = 32'h0420_0080;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on A (latency 1), then verify the result and the trailing bubble
    task automatic run_a(input string tag, input logic [1:0] f, input logic [31:0] x,
                         input logic [3:0] id, input logic [31:0] exp);
        @(negedge clk);
        a_req_valid = 1'b1; a_func = f; a_x = x; a_req_id = id;
        #1 chk({tag, "_rdy"}, 64'(a_req_ready), 64'd1);
        @(negedge clk);
        a_req_valid = 1'b0;
        #1;
        chk({tag, "_vld"}, 64'(a_resp_valid), 64'd1);
        chk({tag, "_data"}, 64'(a_resp_data), 64'(exp));
        chk({tag, "_id"}, 64'(a_resp_id), 64'(id));
    endtask

    // One request on C (latency 2): not valid after one cycle, valid after two
    task automatic run_c(input string tag, input logic [1:0] f, input logic [63:0] x,
                         input logic [3:0] id, input logic [63:0] exp);
        @(negedge clk);
        c_req_valid = 1'b1; c_func = f; c_x = x; c_req_id = id;
        @(negedge clk);
        c_req_valid = 1'b0;
        #1 chk({tag, "_early"}, 64'(c_resp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk({tag, "_vld"}, 64'(c_resp_valid), 64'd1);
        chk({tag, "_data"}, c_resp_data, exp);
        chk({tag, "_id"}, 64'(c_resp_id), 64'(id));
    endtask

    initial begin
        int nxt;
        int got;
        int cyc;
        int e;
        logic [31:0] hold;
        int expq[$];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_vld", 64'(a_resp_valid), 64'd0);
        chk("rst_a_rdy", 64'(a_req_ready), 64'd1);
        chk("rst_b_data", 64'(b_resp_data), 64'd0);
        chk("rst_c_id", 64'(c_resp_id), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_b_vld", 64'(b_resp_valid), 64'd0);
        chk("rel_c_data", c_resp_data, 64'd0);

        // SHA-256, single stage
        run_a("a_sig0_1", 2'd0, 32'h0000_0001, 4'd3, 32'h0200_4000);
        run_a("a_sig1_1", 2'd1, 32'h0000_0001, 4'd5, 32'h0000_A000);
        run_a("a_sum0_1", 2'd2, 32'h0000_0001, 4'd7, 32'h4008_0400);
        run_a("a_sum1_1", 2'd3, 32'h0000_0001, 4'd9, 32'h0420_0080);
        run_a("a_sig0_m", 2'd0, 32'h8000_0000, 4'd1, 32'h1100_2000);
        run_a("a_sig1_m", 2'd1, 32'h8000_0000, 4'd2, 32'h0020_5000);
        run_a("a_sum0_m", 2'd2, 32'h8000_0000, 4'd4, 32'h2004_0200);
        run_a("a_sum1_m", 2'd3, 32'h8000_0000, 4'd15, 32'h0210_0040);
        @(negedge clk);
        #1 chk("a_bubble", 64'(a_resp_valid), 64'd0);

        // SHA-512, two stages
        run_c("c_sig0_1", 2'd0, 64'h1, 4'd6, 64'h8100_0000_0000_0000);
        run_c("c_sig1_1", 2'd1, 64'h1, 4'd8, 64'h0000_2000_0000_0008);
        run_c("c_sum0_1", 2'd2, 64'h1, 4'd10, 64'h0000_0010_4200_0000);
        run_c("c_sum1_1", 2'd3, 64'h1, 4'd11, 64'h0004_4000_0080_0000);
        run_c("c_sig0_m", 2'd0, 64'h8000_0000_0000_0000, 4'd12, 64'h4180_0000_0000_0000);
        run_c("c_sig1_m", 2'd1, 64'h8000_0000_0000_0000, 4'd13, 64'h0200_1000_0000_0004);

        // Back-to-back ids 0..5 on B with resp_ready low in cycles 4..6
        nxt = 0; got = 0; cyc = 0; hold = '0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            b_req_valid  = (nxt < 6);
            b_req_id     = 4'(nxt);
            b_func       = 2'(nxt % 4);
            b_x          = 32'h1;
            b_resp_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                chk("stall_vld", 64'(b_resp_valid), 64'd1);
                chk("stall_rdy", 64'(b_req_ready), 64'd0);
                if (cyc == 4) hold = b_resp_data;
                else chk("stall_data", 64'(b_resp_data), 64'(hold));
            end
            if (b_resp_valid && b_resp_ready) begin
                if (expq.size() == 0) begin
                    chk("extra_resp", 64'(b_resp_id), 64'hFFFF);
                end else begin
                    e = expq.pop_front();
                    chk("ord_id", 64'(b_resp_id), 64'(e));
                    chk("ord_data", 64'(b_resp_data), 64'(tbl_one[e % 4]));
                end
                got++;
            end
            if (b_req_valid && b_req_ready) begin
                expq.push_back(nxt);
                nxt++;
            end
            cyc++;
        end
        b_req_valid = 1'b0;
        b_resp_ready = 1'b1;
        chk("ord_count", 64'(got), 64'd6);
        chk("ord_stall_len", 64'(cyc), 64'd12);

        // Reset with two requests in flight on B
        @(negedge clk);
        b_req_valid = 1'b1; b_req_id = 4'd9; b_func = 2'd0;
        @(negedge clk);
        b_req_id = 4'd10;
        @(negedge clk);
        b_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(b_resp_valid), 64'd0);
        chk("mid_rst_rdy", 64'(b_req_ready), 64'd1);
        chk("mid_rst_data", 64'(b_resp_data), 64'd0);
        chk("mid_rst_id", 64'(b_resp_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("post_rst_vld", 64'(b_resp_valid), 64'd0);
        end

`ifdef SHA2_SIGMA_PERF_CNT_EN
        // Consumed-response counter and wrap
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("perf_rst", 64'(a_perf), 64'd0);
        for (int i = 0; i < 10; i++) begin
            run_a("perf_op", 2'(i % 4), 32'h1, 4'(i), tbl_one[i % 4]);
        end
        @(negedge clk);
        #1 chk("perf_10", 64'(a_perf), 64'd10);
        force dut_a.perf_ops_q = 32'hFFFF_FFFF;
        #1 release dut_a.perf_ops_q;
        run_a("perf_wrap_op", 2'd0, 32'h1, 4'd0, 32'h0200_4000);
        @(negedge clk);
        #1 chk("perf_wrap", 64'(a_perf), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
